// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the execution unit, its stack and the
// controller. Holds the default datapath width and stack depth, and the
// 4-bit instruction opcode encoding.
package cpu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [3:0] {
    OP_HLT  = 4'h0,
    OP_SKZ  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_MUL  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_XOR  = 4'h7,
    OP_NOT  = 4'h8,
    OP_STO  = 4'h9,
    OP_LDA  = 4'hA,
    OP_RL   = 4'hB,
    OP_RR   = 4'hC,
    OP_JMP  = 4'hD,
    OP_POP  = 4'hE,
    OP_PUSH = 4'hF
  } opcode_e;

endpackage

// File: rtl/exec_stack.sv
// exec_stack: hardware LIFO used by the execution unit's PUSH/POP opcodes.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - asynchronous active-low reset (clears sp only)
//   i_push   - push request; ignored when full
//   i_pop    - pop request; ignored when empty
//   i_wdata  - data to push
//   o_rdata  - top-of-stack entry (stack[sp-1]), valid when not empty
//   o_full   - sp == DEPTH
//   o_empty  - sp == 0
module exec_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  // sp counts 0..DEPTH inclusive, so it needs one more state than an index.
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_wr_idx  = AW'(r_sp);
  // Only meaningful when not empty; the pop path is gated on that.
  assign w_rd_idx  = AW'(r_sp - SPW'(1));
  assign o_full    = (r_sp == SPW'(DEPTH));
  assign o_empty   = (r_sp == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Combinational read so a POP can load the accumulator on the same edge.
  assign o_rdata   = r_mem[w_rd_idx];

  // Memory contents are not reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: accumulator-based execution unit with ALU, multiply high word,
// carry flag and a hardware stack.
// Ports:
//   clk          - clock
//   rst          - asynchronous active-low reset
//   opcode       - instruction opcode (cpu_pkg::opcode_e encoding)
//   load_acc     - commit strobe; nothing changes unless it is high
//   datactl_ena  - request to drive acc onto the data bus
//   data_in      - memory operand
//   data_out     - always equal to acc
//   data_oe      - always equal to datactl_ena
//   acc          - accumulator
//   zero         - acc == 0
//   carry        - carry/borrow flag from ADD/SUB
//   mul_hi       - upper half of the last MUL product
//   stack_full   - stack holds DEPTH entries
//   stack_empty  - stack holds no entries
//   stack_err    - sticky: bit0 push overflow, bit1 pop underflow
module exec_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             load_acc,
  input  logic             datactl_ena,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_oe,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             carry,
  output logic [WIDTH-1:0] mul_hi,
  output logic             stack_full,
  output logic             stack_empty,
  output logic [1:0]       stack_err
);

  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [WIDTH-1:0]   r_mul_hi;
  logic [1:0]         r_stack_err;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_pop_data;
  logic               w_push;
  logic               w_pop;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_carry_next;
  logic [WIDTH-1:0]   w_mul_hi_next;
  logic [1:0]         w_stack_err_next;

  assign w_sum  = {1'b0, r_acc} + {1'b0, data_in};
  // The extra top bit of the difference is the unsigned borrow (data_in > acc).
  assign w_diff = {1'b0, r_acc} - {1'b0, data_in};
  assign w_prod = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, data_in};

  assign w_push = load_acc && (opcode_e'(opcode) == OP_PUSH);
  assign w_pop  = load_acc && (opcode_e'(opcode) == OP_POP);

  exec_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (r_acc),
    .o_rdata (w_pop_data),
    .o_full  (stack_full),
    .o_empty (stack_empty)
  );

  always_comb begin
    w_acc_next       = r_acc;
    w_carry_next     = r_carry;
    w_mul_hi_next    = r_mul_hi;
    w_stack_err_next = r_stack_err;
    case (opcode_e'(opcode))
      OP_ADD: begin
        w_acc_next   = w_sum[WIDTH-1:0];
        w_carry_next = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_acc_next   = w_diff[WIDTH-1:0];
        w_carry_next = w_diff[WIDTH];
      end
      OP_MUL: begin
        w_acc_next    = w_prod[WIDTH-1:0];
        w_mul_hi_next = w_prod[2*WIDTH-1:WIDTH];
      end
      OP_OR:  w_acc_next = r_acc | data_in;
      OP_AND: w_acc_next = r_acc & data_in;
      OP_XOR: w_acc_next = r_acc ^ data_in;
      OP_NOT: w_acc_next = ~r_acc;
      OP_LDA: w_acc_next = data_in;
      OP_RL:  w_acc_next = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
      OP_RR:  w_acc_next = {r_acc[0], r_acc[WIDTH-1:1]};
      OP_PUSH: begin
        if (stack_full) begin
          w_stack_err_next[0] = 1'b1;
        end
      end
      OP_POP: begin
        if (stack_empty) begin
          w_stack_err_next[1] = 1'b1;
        end else begin
          w_acc_next = w_pop_data;
        end
      end
      default: ;  // HLT, SKZ, STO, JMP: no state change here
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_mul_hi    <= '0;
      r_stack_err <= '0;
    end else if (load_acc) begin
      r_acc       <= w_acc_next;
      r_carry     <= w_carry_next;
      r_mul_hi    <= w_mul_hi_next;
      r_stack_err <= w_stack_err_next;
    end
  end

  assign acc       = r_acc;
  assign data_out  = r_acc;
  assign data_oe   = datactl_ena;
  assign zero      = (r_acc == '0);
  assign carry     = r_carry;
  assign mul_hi    = r_mul_hi;
  assign stack_err = r_stack_err;

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       load_acc;
  logic       datactl_ena;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] acc;
  logic       zero;
  logic       carry;
  logic [7:0] mul_hi;
  logic       stack_full;
  logic       stack_empty;
  logic [1:0] stack_err;

  int n_total;
  int n_pass;

  exec_unit #(.WIDTH(8), .DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .acc         (acc),
    .zero        (zero),
    .carry       (carry),
    .mul_hi      (mul_hi),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // One committed instruction: drive at negedge, commit on posedge, sample 1ns later.
  task automatic do_op(input logic [3:0] op, input logic [7:0] d);
    @(negedge clk);
    opcode   = op;
    data_in  = d;
    load_acc = 1'b1;
    @(posedge clk);
    #1;
    load_acc = 1'b0;
    $display("op=%h data=%h -> acc=%h carry=%b mul_hi=%h err=%b", op, d, acc, carry, mul_hi, stack_err);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (acc !== 8'h00) $display("FAIL reset_acc: got %h want 00", acc); else n_pass++;
    n_total++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero); else n_pass++;
    n_total++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b want 0", carry); else n_pass++;
    n_total++; if (mul_hi !== 8'h00) $display("FAIL reset_mul_hi: got %h want 00", mul_hi); else n_pass++;
    n_total++; if (stack_empty !== 1'b1 || stack_full !== 1'b0)
      $display("FAIL reset_stack_flags: empty=%b full=%b want 1/0", stack_empty, stack_full); else n_pass++;
    n_total++; if (stack_err !== 2'b00) $display("FAIL reset_stack_err: got %b want 00", stack_err); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add();
    do_op(OP_LDA, 8'h7F);
    n_total++; if (acc !== 8'h7F || zero !== 1'b0) $display("FAIL lda_7f: acc=%h zero=%b want 7f/0", acc, zero); else n_pass++;
    do_op(OP_ADD, 8'h81);
    n_total++; if (acc !== 8'h00) $display("FAIL add_acc: got %h want 00", acc); else n_pass++;
    n_total++; if (carry !== 1'b1) $display("FAIL add_carry: got %b want 1", carry); else n_pass++;
    n_total++; if (zero !== 1'b1) $display("FAIL add_zero: got %b want 1", zero); else n_pass++;
  endtask

  task automatic test_hold();
    // load_acc low: an ADD presented on the bus must not commit
    @(negedge clk);
    opcode  = OP_ADD;
    data_in = 8'h01;
    @(posedge clk);
    #1;
    n_total++; if (acc !== 8'h00 || carry !== 1'b1) $display("FAIL hold_no_load: acc=%h carry=%b want 00/1", acc, carry); else n_pass++;
  endtask

  task automatic test_sub_mul();
    do_op(OP_LDA, 8'h05);
    do_op(OP_SUB, 8'h06);
    n_total++; if (acc !== 8'hFF || carry !== 1'b1) $display("FAIL sub_borrow: acc=%h carry=%b want ff/1", acc, carry); else n_pass++;
    do_op(OP_MUL, 8'h10);
    n_total++; if (acc !== 8'hF0 || mul_hi !== 8'h0F) $display("FAIL mul: acc=%h mul_hi=%h want f0/0f", acc, mul_hi); else n_pass++;
    n_total++; if (carry !== 1'b1) $display("FAIL mul_carry_kept: got %b want 1", carry); else n_pass++;
    do_op(OP_SUB, 8'h01);
    n_total++; if (acc !== 8'hEF || carry !== 1'b0) $display("FAIL sub_no_borrow: acc=%h carry=%b want ef/0", acc, carry); else n_pass++;
    do_op(OP_SUB, 8'hEF);
    n_total++; if (acc !== 8'h00 || carry !== 1'b0 || zero !== 1'b1)
      $display("FAIL sub_equal: acc=%h carry=%b zero=%b want 00/0/1", acc, carry, zero); else n_pass++;
    do_op(OP_LDA, 8'hEF);
    do_op(OP_ADD, 8'h20);
    n_total++; if (acc !== 8'h0F || carry !== 1'b1) $display("FAIL add_wrap: acc=%h carry=%b want 0f/1", acc, carry); else n_pass++;
  endtask

  task automatic test_logic();
    do_op(OP_LDA, 8'hF0);
    do_op(OP_OR, 8'h0F);
    n_total++; if (acc !== 8'hFF) $display("FAIL or: got %h want ff", acc); else n_pass++;
    do_op(OP_AND, 8'h3C);
    n_total++; if (acc !== 8'h3C) $display("FAIL and: got %h want 3c", acc); else n_pass++;
    do_op(OP_XOR, 8'hFF);
    n_total++; if (acc !== 8'hC3) $display("FAIL xor: got %h want c3", acc); else n_pass++;
    do_op(OP_LDA, 8'h81);
    do_op(OP_RL, 8'h00);
    n_total++; if (acc !== 8'h03) $display("FAIL rl: got %h want 03", acc); else n_pass++;
    do_op(OP_RR, 8'h00);
    n_total++; if (acc !== 8'h81) $display("FAIL rr: got %h want 81", acc); else n_pass++;
    do_op(OP_NOT, 8'h55);
    n_total++; if (acc !== 8'h7E) $display("FAIL not: got %h want 7e", acc); else n_pass++;
    n_total++; if (carry !== 1'b1 || mul_hi !== 8'h0F) $display("FAIL logic_flags_kept: carry=%b mul_hi=%h want 1/0f", carry, mul_hi); else n_pass++;
  endtask

  task automatic test_nop_ops();
    logic [3:0] ops [4];
    ops[0] = OP_STO; ops[1] = OP_JMP; ops[2] = OP_HLT; ops[3] = OP_SKZ;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], 8'hAA);
      n_total++;
      if (acc !== 8'h7E || carry !== 1'b1 || mul_hi !== 8'h0F || zero !== 1'b0 || stack_err !== 2'b00 || stack_empty !== 1'b1)
        $display("FAIL nop_%h: acc=%h carry=%b mul_hi=%h zero=%b err=%b empty=%b want 7e/1/0f/0/00/1",
                 ops[i], acc, carry, mul_hi, zero, stack_err, stack_empty);
      else n_pass++;
    end
    @(negedge clk);
    datactl_ena = 1'b1;
    #1;
    n_total++; if (data_oe !== 1'b1 || data_out !== 8'h7E) $display("FAIL data_oe_on: oe=%b out=%h want 1/7e", data_oe, data_out); else n_pass++;
    datactl_ena = 1'b0;
    #1;
    n_total++; if (data_oe !== 1'b0) $display("FAIL data_oe_off: got %b want 0", data_oe); else n_pass++;
  endtask

  task automatic test_stack();
    for (int i = 1; i <= 8; i++) begin
      do_op(OP_LDA, 8'(i));
      do_op(OP_PUSH, 8'h00);
      n_total++;
      if (acc !== 8'(i) || stack_empty !== 1'b0 || stack_full !== (i == 8))
        $display("FAIL push_%0d: acc=%h empty=%b full=%b want %h/0/%b", i, acc, stack_empty, stack_full, 8'(i), (i == 8));
      else n_pass++;
    end
    n_total++; if (stack_err !== 2'b00) $display("FAIL push_no_err: got %b want 00", stack_err); else n_pass++;
    do_op(OP_LDA, 8'h99);
    do_op(OP_PUSH, 8'h00);
    n_total++; if (stack_err !== 2'b01 || stack_full !== 1'b1 || acc !== 8'h99)
      $display("FAIL push_overflow: err=%b full=%b acc=%h want 01/1/99", stack_err, stack_full, acc); else n_pass++;
    for (int i = 8; i >= 1; i--) begin
      do_op(OP_POP, 8'h00);
      n_total++;
      if (acc !== 8'(i) || stack_full !== 1'b0 || stack_empty !== (i == 1))
        $display("FAIL pop_%0d: acc=%h full=%b empty=%b want %h/0/%b", i, acc, stack_full, stack_empty, 8'(i), (i == 1));
      else n_pass++;
    end
    do_op(OP_POP, 8'h00);
    n_total++; if (acc !== 8'h01 || stack_err !== 2'b11 || stack_empty !== 1'b1)
      $display("FAIL pop_underflow: acc=%h err=%b empty=%b want 01/11/1", acc, stack_err, stack_empty); else n_pass++;
    do_op(OP_LDA, 8'h42);
    n_total++; if (stack_err !== 2'b11) $display("FAIL err_sticky: got %b want 11", stack_err); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_op(OP_LDA, 8'h55);
    do_op(OP_PUSH, 8'h00);
    do_op(OP_PUSH, 8'h00);
    n_total++; if (stack_empty !== 1'b0 || acc !== 8'h55) $display("FAIL pre_reset: empty=%b acc=%h want 0/55", stack_empty, acc); else n_pass++;
    // Assert reset between edges with a PUSH pending
    @(negedge clk);
    opcode   = OP_PUSH;
    load_acc = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (acc !== 8'h00 || stack_empty !== 1'b1 || stack_err !== 2'b00 || zero !== 1'b1 || stack_full !== 1'b0)
      $display("FAIL async_reset: acc=%h empty=%b err=%b zero=%b full=%b want 00/1/00/1/0",
               acc, stack_empty, stack_err, zero, stack_full); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (acc !== 8'h00 || stack_empty !== 1'b1) $display("FAIL reset_beats_load: acc=%h empty=%b want 00/1", acc, stack_empty); else n_pass++;
    @(negedge clk);
    load_acc = 1'b0;
    rst      = 1'b1;
    do_op(OP_POP, 8'h00);
    n_total++; if (stack_err !== 2'b10 || acc !== 8'h00) $display("FAIL post_reset_pop: err=%b acc=%h want 10/00", stack_err, acc); else n_pass++;
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst         = 1'b0;
    opcode      = 4'h0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    data_in     = 8'h00;
    test_reset();
    test_add();
    test_hold();
    test_sub_mul();
    test_logic();
    test_nop_ops();
    test_stack();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
